// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the parallel-to-serial sequencer: FSM encoding and
// selector start/end positions derived from the bit order.
package mux_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [1:0] first_sel(input bit lsb_first);
    return lsb_first ? 2'd0 : 2'd3;
  endfunction

  function automatic logic [1:0] last_sel(input bit lsb_first);
    return lsb_first ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/decoder.sv
// 2-to-4 one-hot decoder used as the select stage of the 4:1 multiplexer.
module decoder (
  input  logic [1:0] A,
  output logic [3:0] Y
);

  always_comb begin
    Y = 4'b0001 << A;
  end

endmodule

// File: rtl/multiplexer.sv
// Combinational 4:1 multiplexer built as a one-hot decode followed by AND-OR.
module multiplexer (
  input  logic [3:0] I,
  input  logic [1:0] S,
  output logic       Y
);

  logic [3:0] w_dec;

  decoder u_dec (
    .A(S),
    .Y(w_dec)
  );

  assign Y = |(I & w_dec);

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial sequencer: latches a 4-bit word and walks the mux
// selector through all four positions, holding each bit for BIT_CYCLES clocks.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter bit LSB_FIRST  = 1'b1,
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D_IN,
  input  logic       LOAD,
  output logic       READY,
  output logic [1:0] S,
  output logic       Y_OUT,
  output logic       BIT_VALID,
  output logic       DONE
);

  localparam int              HW        = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic [1:0]      SEL_FIRST = first_sel(LSB_FIRST);
  // Stepping by 3 mod 4 is a decrement, so both directions share one adder.
  localparam logic [1:0]      SEL_STEP  = LSB_FIRST ? 2'd1 : 2'd3;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_word;
  logic [1:0]      r_sel;
  logic [1:0]      r_bit_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_done;

  logic            w_mux_y;
  logic            w_hold_end;
  logic            w_word_end;

  multiplexer u_mux (
    .I(r_word),
    .S(r_sel),
    .Y(w_mux_y)
  );

  assign w_hold_end = (r_hold_cnt == HOLD_LAST);
  assign w_word_end = (r_state == ST_SEND) && w_hold_end && (r_bit_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    READY       = 1'b0;
    BIT_VALID   = 1'b0;
    Y_OUT       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        READY = 1'b1;
        if (LOAD) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        BIT_VALID = 1'b1;
        Y_OUT     = w_mux_y;
        if (w_word_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= 4'b0000;
      r_sel      <= SEL_FIRST;
      r_bit_cnt  <= 2'd0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_word_end;
      if (r_state == ST_IDLE) begin
        if (LOAD) begin
          r_word     <= D_IN;
          r_sel      <= SEL_FIRST;
          r_bit_cnt  <= 2'd0;
          r_hold_cnt <= '0;
        end
      end else if (w_hold_end) begin
        // After the fourth step the selector is back at SEL_FIRST for idle.
        r_hold_cnt <= '0;
        r_sel      <= r_sel + SEL_STEP;
        r_bit_cnt  <= r_bit_cnt + 2'd1;
      end else begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign S    = r_sel;
  assign DONE = r_done;

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial sequencer built around the team's existing 4:1 `multiplexer`.
- Accepts a 4-bit word on a load handshake, holds it in a register, and steps the mux selector through all four positions.
- Emits one bit per bit-period on a serial output with a valid flag, then a done pulse.
- Sits directly upstream of any serial consumer. It is the sequential driver of the selector `S` that the combinational mux stage lacks.

Parameters:
- LSB_FIRST, 1, 1 = send I[0]..I[3] (S = 0,1,2,3); 0 = send I[3]..I[0] (S = 3,2,1,0)
- BIT_CYCLES, 1, clocks each bit is held on Y_OUT; legal range 1..256

Ports:
- clk      input   1  single clock; all state updates on rising edge
- rst      input   1  synchronous, active-high reset
- D_IN     input   4  parallel word; sampled only when LOAD && READY
- LOAD     input   1  load request (valid)
- READY    output  1  block idle and able to accept LOAD
- S        output  2  current selector value, exported for observation
- Y_OUT    output  1  serial data bit
- BIT_VALID output 1  high while Y_OUT carries a payload bit
- DONE     output  1  one-cycle pulse after the last bit period ends

Behaviour:
- Reset (rst = 1 at a rising edge):
  - state goes to IDLE and the word register clears to 0.
  - Bit counter and hold counter clear to 0.
  - S = 0 when LSB_FIRST = 1, or 3 when LSB_FIRST = 0.
  - Outputs: READY = 1, BIT_VALID = 0, Y_OUT = 0, DONE = 0.
  - Reset overrides everything, including mid-word. The partial word is discarded and DONE is not pulsed.
- FSM states: IDLE and SEND.
- IDLE:
  - READY = 1, BIT_VALID = 0, Y_OUT = 0.
  - If LOAD = 1 at an edge: capture D_IN into the word register, load S with the first index, clear both counters, and go to SEND.
- SEND:
  - READY = 0 and BIT_VALID = 1.
  - Y_OUT = the word-register bit selected by S, routed through an instance of `multiplexer` (`I` = word register, `S` = S).
  - The hold counter increments every cycle. When it reaches BIT_CYCLES-1 it wraps to 0 and S advances by one: +1 when LSB_FIRST = 1, -1 when LSB_FIRST = 0.
  - The bit counter also increments at that point.
  - At the wrap that ends bit 3, go to IDLE. DONE is a registered pulse, 1 in the first IDLE cycle only.
- Timing: if LOAD is accepted at edge k, bit 0 is visible in cycle k+1. SEND lasts exactly 4*BIT_CYCLES cycles, and DONE is high in cycle k+1+4*BIT_CYCLES.
- LOAD rules:
  - LOAD while in SEND is ignored. D_IN is not sampled and the word register stays stable.
  - In the DONE cycle READY = 1, so a LOAD there is accepted. Back-to-back words therefore have one idle cycle between them.
- Widths:
  - Hold counter is max(1, $clog2(BIT_CYCLES)) bits.
  - Bit counter is 2 bits.
  - S arithmetic is mod-4. Only the terminal-bit check ends SEND, not the counter value.
- Y_OUT, BIT_VALID and READY are combinational from registered state. There is no combinational path from LOAD or D_IN to any output.

Decomposition:
- Shared package or header:
  - state encoding localparams: ST_IDLE = 1'b0, ST_SEND = 1'b1
  - first/last selector constants derived from LSB_FIRST
- Sub-module: reuse the existing `multiplexer`, and through it `decoder`, unchanged as the data path.
- Counters and FSM live in mux_serializer itself. No further sub-module is needed.

Test Plan:
1. LSB_FIRST = 1, BIT_CYCLES = 1, D_IN = 4'b1010, LOAD pulse at cycle 0 -> cycles 1–4 show S = 0,1,2,3, Y_OUT = 0,1,0,1 and BIT_VALID = 1; DONE = 1 and READY = 1 in cycle 5 only.
2. LSB_FIRST = 0, BIT_CYCLES = 1, D_IN = 4'b1100 -> S = 3,2,1,0 and Y_OUT = 1,1,0,0; DONE in cycle 5.
3. BIT_CYCLES = 3, D_IN = 4'b0110, LSB_FIRST = 1 -> Y_OUT = 0,0,0,1,1,1,1,1,1,0,0,0 over cycles 1–12; DONE in cycle 13.
4. D_IN = 4'b1111 loaded, then LOAD with D_IN = 4'b0000 at cycle 2 -> Y_OUT stays 1 for all 4 bits; the second LOAD is not accepted and READY = 0 at cycle 2.
5. D_IN = 4'b0101 loaded, rst = 1 at cycle 2 -> cycle 3 shows READY = 1, BIT_VALID = 0, Y_OUT = 0, S = 0, and no DONE. A new LOAD of 4'b0011 then serializes 1,1,0,0 correctly.
6. Back-to-back: LOAD = 1 held continuously with D_IN = 4'b1001, then 4'b0110 -> the second word is accepted in the DONE cycle (cycle 5), and bits 0,1,1,0 appear in cycles 6–9.
